// File: rtl/jelly2_rtos_pkg.sv
// ---------------------------------------------------------------------------
// jelly2_rtos_pkg
//   Shared definitions for the RTOS core wait-queue blocks.
//   - qmode_t     : ordering mode of one logical wait queue
//   - que_width_f : queue-select width, never narrower than one bit
// Entry records depend on module parameters, so they are declared locally in
// the modules that hold them.
// ---------------------------------------------------------------------------
package jelly2_rtos_pkg;

    typedef enum logic {
        QMODE_FIFO = 1'b0,
        QMODE_PRI  = 1'b1
    } qmode_t;

    function automatic int que_width_f(input int que_num);
        return (que_num > 1) ? $clog2(que_num) : 1;
    endfunction

endpackage

// File: rtl/jelly2_rtos_queue_select.sv
// ---------------------------------------------------------------------------
// jelly2_rtos_queue_select
//   Combinational head selector for one logical queue over the shared pool.
//   Ports:
//     mode_i  : QMODE_FIFO -> lowest-index member wins
//               QMODE_PRI  -> lowest pri wins, ties to the lowest index
//     valid_i / id_i / pri_i / que_i : pool entries, index 0 = oldest
//     valid_o / id_o / pri_o         : selected head (0 when queue empty)
// ---------------------------------------------------------------------------
module jelly2_rtos_queue_select
    import jelly2_rtos_pkg::*;
#(
    parameter int                   QUE_SIZE  = 16,
    parameter int                   ID_WIDTH  = 4,
    parameter int                   PRI_WIDTH = 4,
    parameter int                   QUE_WIDTH = 2,
    parameter logic [QUE_WIDTH-1:0] QUE_SEL   = '0
)(
    input  qmode_t                              mode_i,
    input  logic [QUE_SIZE-1:0]                 valid_i,
    input  logic [QUE_SIZE-1:0][ID_WIDTH-1:0]   id_i,
    input  logic [QUE_SIZE-1:0][PRI_WIDTH-1:0]  pri_i,
    input  logic [QUE_SIZE-1:0][QUE_WIDTH-1:0]  que_i,
    output logic                                valid_o,
    output logic [ID_WIDTH-1:0]                 id_o,
    output logic [PRI_WIDTH-1:0]                pri_o
);

    logic                 found;
    logic [ID_WIDTH-1:0]  best_id;
    logic [PRI_WIDTH-1:0] best_pri;

    // Linear scan from the oldest entry; a later entry only displaces the
    // current pick when it is strictly better, which gives index tie-break.
    always_comb begin
        found    = 1'b0;
        best_id  = '0;
        best_pri = '0;
        for (int i = 0; i < QUE_SIZE; i++) begin
            if (valid_i[i] && (que_i[i] == QUE_SEL)) begin
                if (!found || ((mode_i == QMODE_PRI) && (pri_i[i] < best_pri))) begin
                    found    = 1'b1;
                    best_id  = id_i[i];
                    best_pri = pri_i[i];
                end
            end
        end
    end

    assign valid_o = found;
    assign id_o    = best_id;
    assign pri_o   = best_pri;

endmodule

// File: rtl/jelly2_rtos_queue_multi.sv
// ---------------------------------------------------------------------------
// jelly2_rtos_queue_multi
//   Multi-channel RTOS wait queue. One shared, arrival-ordered pool of task
//   IDs, each tagged with a logical queue number; each queue presents a
//   registered head (priority or FIFO ordered, chosen by PRI_ORDER).
//   Ports:
//     clk, reset (sync, active-high), cke (clock enable, holds everything)
//     add_*      : enqueue id/pri into queue add_que (duplicate id re-enqueues)
//     remove_*   : drop the entry with remove_id from whichever queue holds it
//     chgpri_*   : change the priority of a queued id in place
//     top_*      : per-queue head, two cycles after the request
//     count      : per-queue occupancy, total : pool occupancy, full
//     add_error  : one-cycle pulse when an add is dropped
// ---------------------------------------------------------------------------
module jelly2_rtos_queue_multi
    import jelly2_rtos_pkg::*;
#(
    parameter int                 QUE_NUM     = 4,
    parameter int                 QUE_SIZE    = 16,
    parameter int                 ID_WIDTH    = 4,
    parameter int                 PRI_WIDTH   = 4,
    parameter int                 QUE_WIDTH   = que_width_f(QUE_NUM),
    parameter int                 COUNT_WIDTH = $clog2(QUE_SIZE + 1),
    parameter logic [QUE_NUM-1:0] PRI_ORDER   = {QUE_NUM{1'b1}}
)(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cke,
    input  logic [ID_WIDTH-1:0]                  add_id,
    input  logic [PRI_WIDTH-1:0]                 add_pri,
    input  logic [QUE_WIDTH-1:0]                 add_que,
    input  logic                                 add_valid,
    input  logic [ID_WIDTH-1:0]                  remove_id,
    input  logic                                 remove_valid,
    input  logic [ID_WIDTH-1:0]                  chgpri_id,
    input  logic [PRI_WIDTH-1:0]                 chgpri_pri,
    input  logic                                 chgpri_valid,
    output logic [QUE_NUM-1:0][ID_WIDTH-1:0]     top_id,
    output logic [QUE_NUM-1:0][PRI_WIDTH-1:0]    top_pri,
    output logic [QUE_NUM-1:0]                   top_valid,
    output logic [QUE_NUM-1:0][COUNT_WIDTH-1:0]  count,
    output logic [COUNT_WIDTH-1:0]               total,
    output logic                                 full,
    output logic                                 add_error
);

    typedef struct packed {
        logic                 valid;
        logic [ID_WIDTH-1:0]  id;
        logic [PRI_WIDTH-1:0] pri;
        logic [QUE_WIDTH-1:0] que;
    } entry_t;

    localparam logic [COUNT_WIDTH-1:0] SIZE_V = COUNT_WIDTH'(QUE_SIZE);
    localparam logic [QUE_WIDTH:0]     QNUM_V = (QUE_WIDTH + 1)'(QUE_NUM);

    entry_t                          pool_q [QUE_SIZE];
    entry_t                          pool_d [QUE_SIZE];
    entry_t                          stage  [QUE_SIZE];
    logic [COUNT_WIDTH-1:0]          rank   [QUE_SIZE];
    logic [COUNT_WIDTH-1:0]          live_cnt;
    logic                            add_ok;
    logic                            add_err_d;
    logic [COUNT_WIDTH-1:0]          total_d;
    logic [QUE_NUM-1:0][COUNT_WIDTH-1:0] count_d;

    logic [QUE_NUM-1:0][COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0]              total_q;
    logic                                full_q;
    logic                                add_error_q;
    logic [QUE_NUM-1:0]                  top_valid_q;
    logic [QUE_NUM-1:0][ID_WIDTH-1:0]    top_id_q;
    logic [QUE_NUM-1:0][PRI_WIDTH-1:0]   top_pri_q;

    always_comb begin
        // Kill removed ids and the add id (so a duplicate add moves to the
        // tail), then retag priority on whatever survived.
        for (int i = 0; i < QUE_SIZE; i++) begin
            stage[i] = pool_q[i];
            if ((remove_valid && (pool_q[i].id == remove_id)) ||
                (add_valid    && (pool_q[i].id == add_id))) begin
                stage[i].valid = 1'b0;
            end
            if (chgpri_valid && stage[i].valid && (stage[i].id == chgpri_id)) begin
                stage[i].pri = chgpri_pri;
            end
        end

        // Destination slot of each survivor = number of survivors before it.
        live_cnt = '0;
        for (int i = 0; i < QUE_SIZE; i++) begin
            rank[i] = live_cnt;
            if (stage[i].valid) begin
                live_cnt = live_cnt + COUNT_WIDTH'(1);
            end
        end

        add_ok    = add_valid && ({1'b0, add_que} < QNUM_V) && (live_cnt < SIZE_V);
        add_err_d = add_valid && !add_ok;
        total_d   = live_cnt + COUNT_WIDTH'(add_ok);

        for (int j = 0; j < QUE_SIZE; j++) begin
            pool_d[j] = '0;
            for (int i = 0; i < QUE_SIZE; i++) begin
                if (stage[i].valid && (rank[i] == COUNT_WIDTH'(j))) begin
                    pool_d[j] = stage[i];
                end
            end
            if (add_ok && (live_cnt == COUNT_WIDTH'(j))) begin
                pool_d[j].valid = 1'b1;
                pool_d[j].id    = add_id;
                pool_d[j].pri   = add_pri;
                pool_d[j].que   = add_que;
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int q = 0; q < QUE_NUM; q++) begin
            for (int i = 0; i < QUE_SIZE; i++) begin
                if (pool_d[i].valid && (pool_d[i].que == QUE_WIDTH'(q))) begin
                    count_d[q] = count_d[q] + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // Heads are selected from the registered pool, adding one cycle.
    logic [QUE_SIZE-1:0]                ent_valid;
    logic [QUE_SIZE-1:0][ID_WIDTH-1:0]  ent_id;
    logic [QUE_SIZE-1:0][PRI_WIDTH-1:0] ent_pri;
    logic [QUE_SIZE-1:0][QUE_WIDTH-1:0] ent_que;
    logic [QUE_NUM-1:0]                 sel_valid;
    logic [QUE_NUM-1:0][ID_WIDTH-1:0]   sel_id;
    logic [QUE_NUM-1:0][PRI_WIDTH-1:0]  sel_pri;

    always_comb begin
        for (int i = 0; i < QUE_SIZE; i++) begin
            ent_valid[i] = pool_q[i].valid;
            ent_id[i]    = pool_q[i].id;
            ent_pri[i]   = pool_q[i].pri;
            ent_que[i]   = pool_q[i].que;
        end
    end

    for (genvar q = 0; q < QUE_NUM; q++) begin : g_que
        jelly2_rtos_queue_select #(
            .QUE_SIZE  (QUE_SIZE),
            .ID_WIDTH  (ID_WIDTH),
            .PRI_WIDTH (PRI_WIDTH),
            .QUE_WIDTH (QUE_WIDTH),
            .QUE_SEL   (QUE_WIDTH'(q))
        ) u_select (
            .mode_i  (qmode_t'(PRI_ORDER[q])),
            .valid_i (ent_valid),
            .id_i    (ent_id),
            .pri_i   (ent_pri),
            .que_i   (ent_que),
            .valid_o (sel_valid[q]),
            .id_o    (sel_id[q]),
            .pri_o   (sel_pri[q])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < QUE_SIZE; i++) begin
                pool_q[i] <= '0;
            end
            count_q     <= '0;
            total_q     <= '0;
            full_q      <= 1'b0;
            add_error_q <= 1'b0;
            top_valid_q <= '0;
            top_id_q    <= '0;
            top_pri_q   <= '0;
        end else if (cke) begin
            for (int i = 0; i < QUE_SIZE; i++) begin
                pool_q[i] <= pool_d[i];
            end
            count_q     <= count_d;
            total_q     <= total_d;
            full_q      <= (total_d == SIZE_V);
            add_error_q <= add_err_d;
            top_valid_q <= sel_valid;
            // An empty queue keeps showing its last head id/pri.
            for (int q = 0; q < QUE_NUM; q++) begin
                if (sel_valid[q]) begin
                    top_id_q[q]  <= sel_id[q];
                    top_pri_q[q] <= sel_pri[q];
                end
            end
        end
    end

    assign top_id    = top_id_q;
    assign top_pri   = top_pri_q;
    assign top_valid = top_valid_q;
    assign count     = count_q;
    assign total     = total_q;
    assign full      = full_q;
    assign add_error = add_error_q;

endmodule

// File: tb/tb_jelly2_rtos_queue_multi.sv
// ---------------------------------------------------------------------------
// tb_jelly2_rtos_queue_multi
//   Self-checking bench: directed scenarios followed by random traffic, all
//   compared against an ordered-list reference model of the wait pool.
//   Three queues (one out-of-range select value exists), 5-bit IDs so the
//   pool can genuinely overflow with distinct IDs.
// ---------------------------------------------------------------------------
module tb_jelly2_rtos_queue_multi;

    localparam int             QN = 3;
    localparam int             QS = 16;
    localparam int             IW = 5;
    localparam int             PW = 4;
    localparam int             QW = 2;
    localparam int             CW = 5;
    localparam logic [QN-1:0]  PO = 3'b101;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    cke;
    logic [IW-1:0]           add_id;
    logic [PW-1:0]           add_pri;
    logic [QW-1:0]           add_que;
    logic                    add_valid;
    logic [IW-1:0]           remove_id;
    logic                    remove_valid;
    logic [IW-1:0]           chgpri_id;
    logic [PW-1:0]           chgpri_pri;
    logic                    chgpri_valid;
    logic [QN-1:0][IW-1:0]   top_id;
    logic [QN-1:0][PW-1:0]   top_pri;
    logic [QN-1:0]           top_valid;
    logic [QN-1:0][CW-1:0]   count;
    logic [CW-1:0]           total;
    logic                    full;
    logic                    add_error;

    jelly2_rtos_queue_multi #(
        .QUE_NUM   (QN),
        .QUE_SIZE  (QS),
        .ID_WIDTH  (IW),
        .PRI_WIDTH (PW),
        .PRI_ORDER (PO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cke          (cke),
        .add_id       (add_id),
        .add_pri      (add_pri),
        .add_que      (add_que),
        .add_valid    (add_valid),
        .remove_id    (remove_id),
        .remove_valid (remove_valid),
        .chgpri_id    (chgpri_id),
        .chgpri_pri   (chgpri_pri),
        .chgpri_valid (chgpri_valid),
        .top_id       (top_id),
        .top_pri      (top_pri),
        .top_valid    (top_valid),
        .count        (count),
        .total        (total),
        .full         (full),
        .add_error    (add_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int pri;
        int que;
    } ment_t;

    ment_t mq[$];
    int    exp_err;
    int    exp_tv   [QN];
    int    exp_tid  [QN];
    int    exp_tpri [QN];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Head of queue q in the model: FIFO -> oldest member; priority ->
    // oldest among the members holding the smallest priority value.
    function automatic int head_idx(input int q);
        int mn;
        int idx;
        mn  = 1000;
        idx = -1;
        if (PO[q]) begin
            foreach (mq[i]) if (mq[i].que == q && mq[i].pri < mn) mn = mq[i].pri;
        end
        foreach (mq[i]) begin
            if (idx < 0 && mq[i].que == q && (!PO[q] || mq[i].pri == mn)) idx = i;
        end
        return idx;
    endfunction

    task automatic check_outputs();
        int c;
        check_val("total", int'(total), mq.size());
        check_val("full", int'(full), int'(mq.size() == QS));
        check_val("add_error", int'(add_error), exp_err);
        for (int q = 0; q < QN; q++) begin
            c = 0;
            foreach (mq[i]) if (mq[i].que == q) c++;
            check_val($sformatf("count%0d", q), int'(count[q]), c);
            check_val($sformatf("top_valid%0d", q), int'(top_valid[q]), exp_tv[q]);
            if (exp_tv[q] != 0) begin
                check_val($sformatf("top_id%0d", q), int'(top_id[q]), exp_tid[q]);
                check_val($sformatf("top_pri%0d", q), int'(top_pri[q]), exp_tpri[q]);
            end
        end
    endtask

    task automatic step(input bit av, input int aid, input int ap, input int aq,
                        input bit rv, input int rid,
                        input bit cv, input int cid, input int cp, input bit ck);
        int h;
        add_valid    = av;  add_id    = IW'(aid); add_pri = PW'(ap); add_que = QW'(aq);
        remove_valid = rv;  remove_id = IW'(rid);
        chgpri_valid = cv;  chgpri_id = IW'(cid); chgpri_pri = PW'(cp);
        cke          = ck;
        if (ck) begin
            // Heads seen after this edge come from the pool before this request.
            for (int q = 0; q < QN; q++) begin
                h = head_idx(q);
                exp_tv[q] = (h >= 0) ? 1 : 0;
                if (h >= 0) begin
                    exp_tid[q]  = mq[h].id;
                    exp_tpri[q] = mq[h].pri;
                end
            end
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if ((rv && mq[i].id == rid) || (av && mq[i].id == aid)) mq.delete(i);
            end
            if (cv) foreach (mq[i]) if (mq[i].id == cid) mq[i].pri = cp;
            exp_err = 0;
            if (av) begin
                if (aq < QN && mq.size() < QS) mq.push_back('{aid, ap, aq});
                else exp_err = 1;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic add(input int id, input int pri, input int que);
        step(1, id, pri, que, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset(input bit with_add);
        reset = 1'b1; cke = 1'b1;
        add_valid = with_add; add_id = 5'd9; add_pri = 4'd1; add_que = 2'd0;
        remove_valid = 1'b0; chgpri_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0; add_valid = 1'b0;
        mq.delete();
        exp_err = 0;
        for (int q = 0; q < QN; q++) begin
            exp_tv[q] = 0; exp_tid[q] = 0; exp_tpri[q] = 0;
        end
        check_outputs();
        for (int q = 0; q < QN; q++) begin
            check_val($sformatf("rst_top_id%0d", q), int'(top_id[q]), 0);
            check_val($sformatf("rst_top_pri%0d", q), int'(top_pri[q]), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rid;
        int cid;
        reset = 1'b1; cke = 1'b1;
        add_valid = 1'b0; add_id = '0; add_pri = '0; add_que = '0;
        remove_valid = 1'b0; remove_id = '0;
        chgpri_valid = 1'b0; chgpri_id = '0; chgpri_pri = '0;
        do_reset(0);

        // Priority queue ordering
        add(3, 5, 0);
        add(7, 2, 0);
        idle();
        check_val("prio_top_id", int'(top_id[0]), 7);
        check_val("prio_top_pri", int'(top_pri[0]), 2);
        check_val("prio_count", int'(count[0]), 2);

        // FIFO queue ordering and remove
        do_reset(0);
        add(3, 5, 1);
        add(7, 2, 1);
        idle();
        check_val("fifo_top_id", int'(top_id[1]), 3);
        step(0, 0, 0, 0, 1, 3, 0, 0, 0, 1);
        check_val("fifo_count_after_rm", int'(count[1]), 1);
        idle();
        check_val("fifo_top_after_rm", int'(top_id[1]), 7);

        // In-place priority change and tie-break
        do_reset(0);
        add(1, 4, 0);
        add(2, 6, 0);
        idle();
        check_val("chg_top_before", int'(top_id[0]), 1);
        step(0, 0, 0, 0, 0, 0, 1, 2, 1, 1);
        idle();
        check_val("chg_top_raised", int'(top_id[0]), 2);
        step(0, 0, 0, 0, 0, 0, 1, 2, 4, 1);
        idle();
        check_val("chg_top_tie", int'(top_id[0]), 1);
        check_val("chg_top_tie_pri", int'(top_pri[0]), 4);

        // Overflow
        do_reset(0);
        for (int i = 0; i < QS; i++) add(i, i % 16, i % 3);
        check_val("fill_full", int'(full), 1);
        check_val("fill_total", int'(total), 16);
        add(20, 3, 0);
        check_val("ovf_error", int'(add_error), 1);
        check_val("ovf_total", int'(total), 16);
        idle();
        check_val("ovf_error_pulse", int'(add_error), 0);
        step(1, 21, 2, 2, 1, 0, 0, 0, 0, 1);
        check_val("swap_error", int'(add_error), 0);
        check_val("swap_total", int'(total), 16);

        // Same-cycle add+remove of the FIFO head re-appends it at the tail
        idle();
        check_val("readd_head_before", int'(top_id[1]), 1);
        step(1, 1, 1, 1, 1, 1, 0, 0, 0, 1);
        check_val("readd_count", int'(count[1]), 5);
        idle();
        check_val("readd_head_after", int'(top_id[1]), 4);

        // Out-of-range queue select
        do_reset(0);
        add(4, 1, 3);
        check_val("badque_error", int'(add_error), 1);
        check_val("badque_total", int'(total), 0);

        // Reset discards a simultaneous add
        add(6, 2, 0);
        add(8, 3, 2);
        do_reset(1);
        idle();
        check_val("rst_no_retain", int'(total), 0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset($urandom_range(1));
            rid = $urandom_range(19);
            cid = $urandom_range(19);
            if (mq.size() > 0 && $urandom_range(1) == 1) rid = mq[$urandom_range(mq.size() - 1)].id;
            if (mq.size() > 0 && $urandom_range(1) == 1) cid = mq[$urandom_range(mq.size() - 1)].id;
            step($urandom_range(99) < 60, $urandom_range(19), $urandom_range(15),
                 ($urandom_range(9) == 0) ? 3 : $urandom_range(2),
                 $urandom_range(99) < 30, rid,
                 $urandom_range(99) < 30, cid, $urandom_range(15),
                 $urandom_range(9) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
